// File: rtl/aes_pkg.sv
// Shared AES constants, Rcon table, round-key array type and key-schedule FSM states.
package aes_pkg;

   localparam int AES_NR     = 10;
   localparam int AES_KEY_W  = 128;
   localparam int AES_WORD_W = 32;

   localparam logic [7:0] AES_RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef logic [0:10][AES_KEY_W-1:0] aes_rk_t;

   typedef enum logic [1:0] {
      KE_IDLE   = 2'd0,
      KE_EXPAND = 2'd1,
      KE_DONE   = 2'd2
   } ke_state_e;

   // Round indices outside 1..10 never reach the datapath; they map to zero.
   function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      rc = 8'h00;
      if (rnd >= 4'd1 && rnd <= 4'd10) rc = AES_RCON[rnd];
      return rc;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

   // Addition chain for x^254; zero maps to zero as the S-box requires.
   always_comb begin
      x2   = gf_mul(in_byte, in_byte);
      x3   = gf_mul(x2, in_byte);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      inv  = gf_mul(x252, x2);
      out_byte = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
   end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry register file.
// Optional round-key stream output enabled by defining AES_KEY_EXPAND_STREAM_EN.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_valid,
   input  logic [AES_KEY_W-1:0] key_in,
   output logic                 key_ready,
   output logic                 done,
   input  logic [3:0]           rd_idx,
   output logic [AES_KEY_W-1:0] rd_key,
`ifdef AES_KEY_EXPAND_STREAM_EN
   output logic                 rk_stream_valid,
   output logic [3:0]           rk_stream_idx,
   output logic [AES_KEY_W-1:0] rk_stream_key,
`endif
   output logic [1:0]           state_dbg
);

   generate
      if (NR != 10) begin : g_bad_nr
         $error("aes_key_expand: only NR = 10 (AES-128) is supported");
      end
   endgenerate

   ke_state_e            state_q, state_d;
   logic [AES_KEY_W-1:0] work_q, work_d;
   logic [3:0]           rnd_q, rnd_d;
   aes_rk_t              rk_q, rk_d;
   logic [AES_KEY_W-1:0] rd_key_q, rd_key_d;

   logic [AES_WORD_W-1:0] w3_rot, w3_sub, t_word;
   logic [AES_WORD_W-1:0] nw0, nw1, nw2, nw3;
   logic [AES_KEY_W-1:0]  next_rk;
   logic                  accept;

   // Handshake: a key transfers on a rising edge where key_valid && key_ready;
   // key_ready depends only on state, never on key_valid.
   assign key_ready = (state_q != KE_EXPAND);
   assign done      = (state_q == KE_DONE);
   assign accept    = key_valid && key_ready;
   assign rd_key    = rd_key_q;
   assign state_dbg = state_q;

   assign w3_rot = {work_q[23:0], work_q[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sub
      aes_sbox u_sbox (
         .in_byte  (w3_rot[8*i +: 8]),
         .out_byte (w3_sub[8*i +: 8])
      );
   end

   assign t_word  = w3_sub ^ {aes_rcon(rnd_q), 24'h000000};
   assign nw0     = work_q[127:96] ^ t_word;
   assign nw1     = work_q[95:64]  ^ nw0;
   assign nw2     = work_q[63:32]  ^ nw1;
   assign nw3     = work_q[31:0]   ^ nw2;
   assign next_rk = {nw0, nw1, nw2, nw3};

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rnd_d   = rnd_q;
      rk_d    = rk_q;
      case (state_q)
         KE_IDLE, KE_DONE: begin
            if (accept) begin
               rk_d[0] = key_in;
               work_d  = key_in;
               rnd_d   = 4'd1;
               state_d = KE_EXPAND;
            end
         end
         KE_EXPAND: begin
            rk_d[rnd_q] = next_rk;
            work_d      = next_rk;
            rnd_d       = rnd_q + 4'd1;
            if (rnd_q == 4'd10) state_d = KE_DONE;
         end
         default: state_d = KE_IDLE;
      endcase
      rd_key_d = (rd_idx <= 4'd10) ? rk_q[rd_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= KE_IDLE;
         rnd_q    <= 4'd0;
         rd_key_q <= '0;
      end else begin
         state_q  <= state_d;
         rnd_q    <= rnd_d;
         rd_key_q <= rd_key_d;
      end
   end

   // Key storage survives reset; consumers only trust it once done is high.
   always_ff @(posedge clk) begin
      work_q <= work_d;
      rk_q   <= rk_d;
   end

`ifdef AES_KEY_EXPAND_STREAM_EN
   logic                 stream_valid_q, stream_valid_d;
   logic [3:0]           stream_idx_q, stream_idx_d;
   logic [AES_KEY_W-1:0] stream_key_q, stream_key_d;

   always_comb begin
      stream_valid_d = 1'b0;
      stream_idx_d   = stream_idx_q;
      stream_key_d   = stream_key_q;
      if (accept) begin
         stream_valid_d = 1'b1;
         stream_idx_d   = 4'd0;
         stream_key_d   = key_in;
      end else if (state_q == KE_EXPAND) begin
         stream_valid_d = 1'b1;
         stream_idx_d   = rnd_q;
         stream_key_d   = next_rk;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stream_valid_q <= 1'b0;
         stream_idx_q   <= 4'd0;
         stream_key_q   <= '0;
      end else begin
         stream_valid_q <= stream_valid_d;
         stream_idx_q   <= stream_idx_d;
         stream_key_q   <= stream_key_d;
      end
   end

   assign rk_stream_valid = stream_valid_q;
   assign rk_stream_idx   = stream_idx_q;
   assign rk_stream_key   = stream_key_q;
`endif

endmodule
